// File: rtl/uart_frame_tx.sv
// 8N1 UART transmitter sending a fixed 6-byte frame per accepted word:
// two header bytes, then the 32-bit word MSB byte first.
module uart_frame_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  HDR_BYTE     = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic        ready,
    output logic        tx,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] LP_BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LP_LAST_BYTE = 3'd5;
    localparam logic [2:0]  LP_LAST_BIT  = 3'd7;

    state_t      r_state;
    logic [15:0] r_baud;
    logic [2:0]  r_bit_idx;
    logic [2:0]  r_byte_idx;
    logic [31:0] r_hold;
    logic [7:0]  r_shift;
    logic        r_tx;
    logic        r_ready;
    logic        r_busy;

    logic        w_bit_end;
    logic        w_accept;

    // Byte n of the frame: header twice, then the held word MSB byte first.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [31:0] word);
        case (idx)
            3'd0, 3'd1: frame_byte = HDR_BYTE;
            3'd2:       frame_byte = word[31:24];
            3'd3:       frame_byte = word[23:16];
            3'd4:       frame_byte = word[15:8];
            default:    frame_byte = word[7:0];
        endcase
    endfunction

    assign w_bit_end = (r_baud == LP_BAUD_LAST);
    assign w_accept  = data_valid & r_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_hold     <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_baud     <= '0;
                    r_bit_idx  <= '0;
                    r_byte_idx <= '0;
                    r_tx       <= 1'b1;
                    if (w_accept) begin
                        r_hold  <= data_in;
                        r_shift <= HDR_BYTE;
                        r_tx    <= 1'b0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_baud    <= '0;
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                DATA: begin
                    // Bit 0 went out at the end of START, so bit_idx counts bits already on the line.
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == LP_LAST_BIT) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        if (r_byte_idx < LP_LAST_BYTE) begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                            r_shift    <= frame_byte(r_byte_idx + 3'd1, r_hold);
                            r_tx       <= 1'b0;
                            r_state    <= START;
                        end else begin
                            r_byte_idx <= '0;
                            r_ready    <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx    = r_tx;
    assign ready = r_ready;
    assign busy  = r_busy;

endmodule

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit; legal range 2..65535.
REQ-002 Parameter HDR_BYTE, default 8'hFF, header byte sent twice at the start of every frame.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high; clk and rst are the block's only clock and reset.
REQ-005 data_in  input  32  word to transmit; sampled only on the accept edge.
REQ-006 data_valid  input  1  request to send data_in.
REQ-007 ready  output  1  high when the block can accept a word; registered.
REQ-008 tx  output  1  UART serial line, 8N1, idle high; registered.
REQ-009 busy  output  1  high while a frame is in progress; the inverse of ready.

Function
REQ-010 Accept occurs on a rising edge where data_valid=1 and ready=1.
- data_in is latched into a 32-bit holding register on that edge.
- data_valid while ready=0 is ignored and has no effect.
REQ-011 Frame byte order:
- HDR_BYTE, HDR_BYTE, then data_in[31:24], [23:16], [15:8], [7:0].
- 6 bytes total, sent back to back with no idle gap between bytes.
REQ-012 Each byte is one start bit (0), eight data bits LSB first, and one stop bit (1).
- Every bit holds tx constant for exactly CLKS_PER_BIT cycles.
REQ-013 State machine states: IDLE, START, DATA, STOP.
- IDLE->START on accept.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->STOP after 8 bits.
- STOP->START if the byte index is below 5, otherwise STOP->IDLE, in both cases after CLKS_PER_BIT cycles.
REQ-014 Counters:
- Baud counter 16 bits, 0..CLKS_PER_BIT-1, cleared on every bit boundary.
- Bit index 3 bits, 0..7.
- Byte index 3 bits, 0..5; it never exceeds 5.
REQ-015 Latency: tx is 0 (start bit) from the accept edge through the following CLKS_PER_BIT cycles.
- The first data bit appears on the edge accept+CLKS_PER_BIT.
REQ-016 Frame length: the final stop bit ends on the edge accept+60*CLKS_PER_BIT.
- On that edge ready rises to 1 and busy falls to 0.
REQ-017 Back-to-back frames: with data_valid held high, the next accept occurs one cycle after ready rises.
- The last stop bit of the previous frame is therefore CLKS_PER_BIT+1 cycles long.
- Maximum rate is one frame per 60*CLKS_PER_BIT+1 cycles.
REQ-018 data_in changes after the accept edge shall not alter the frame in progress.
REQ-019 In IDLE, tx=1 and the baud, bit and byte counters are held at 0.

Reset
REQ-020 While rst=1, the outputs are forced immediately, independent of clk:
- tx=1, ready=1, busy=0.
- State IDLE, all counters 0, holding register 0.
REQ-021 Reset asserted mid-frame aborts the frame; tx returns to 1 without completing the current bit.
REQ-022 An accept is not possible on any edge where rst=1.
REQ-023 After rst deasserts, the first accept may occur on the first rising edge with data_valid=1.

Verification
REQ-024 CLKS_PER_BIT=8, send 32'h05F5E0FE:
- The bench decodes tx bytes FF, FF, 05, F5, E0, FE, each with start=0 and stop=1.
- Every bit is 8 cycles wide.
- ready rises exactly 480 cycles after the accept edge.
REQ-025 CLKS_PER_BIT=8, data_valid held high with two words 32'h00000000 then 32'hFFFFFFFF:
- Second accept occurs 481 cycles after the first.
- Both frames decode correctly with no spurious start bit between them.
REQ-026 CLKS_PER_BIT=8, toggle data_in and pulse data_valid during a frame:
- The frame content equals the accepted word.
- No second frame starts until ready=1.
REQ-027 CLKS_PER_BIT=8, assert rst for 3 cycles during the third byte:
- tx=1 and ready=1 within the same cycle rst rises, with no further transitions on tx.
- After release, a new word transmits completely and correctly.
REQ-028 Default CLKS_PER_BIT=868, send 32'h12345678:
- The start bit lasts 868 cycles.
- Total frame time is 52080 cycles.
- Bytes decode as FF, FF, 12, 34, 56, 78.
